// File: rtl/mxrv_ifu.sv
// mxrv_ifu: pipelined instruction fetch unit with in-order outstanding bus requests and a PC/instruction FIFO.
// Optional misaligned-fetch check is enabled by defining MXRV_IFU_MISALIGN_CHK_EN.
module mxrv_ifu #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            fault_o
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   live_q;
    logic [CW-1:0]   discard_q;

    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wr_q;
    logic [TW-1:0]   tag_rd_q;

    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_inst [FIFO_DEPTH];
    logic [FW-1:0]   fifo_wr_q;
    logic [FW-1:0]   fifo_rd_q;
    logic [FCW-1:0]  fifo_count_q;

    logic [31:0] bus_used;
    logic [31:0] buf_used;
    logic        pc_misaligned;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_take;
    logic        rsp_consumed;
    logic        fifo_push;
    logic        fifo_pop;

`ifdef MXRV_IFU_MISALIGN_CHK_EN
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif

    // Bus credits cover both live and to-be-discarded requests; buffer credits reserve FIFO room for every live request.
    assign bus_used = 32'(live_q) + 32'(discard_q);
    assign buf_used = 32'(fifo_count_q) + 32'(live_q);

    assign mem_req_valid_o = !rst && !jump_i && !hold_i && !pc_misaligned
                             && (bus_used < 32'(MAX_OUTSTANDING))
                             && (buf_used < 32'(FIFO_DEPTH));
    assign mem_req_addr_o  = pc_q;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;

    assign rsp_drop     = mem_rsp_valid_i && (discard_q != '0);
    assign rsp_take     = mem_rsp_valid_i && (discard_q == '0) && (live_q != '0);
    assign rsp_consumed = rsp_drop || rsp_take;

    assign fifo_push = rsp_take && !jump_i;
    assign fifo_pop  = (fifo_count_q != '0) && id_ready_i && !jump_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (jump_i) begin
            pc_q <= jump_addr_i;
        end else if (req_fire) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // On a jump every request still on the bus becomes a discard, minus the one answered in the jump cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q    <= '0;
            discard_q <= '0;
        end else if (jump_i) begin
            live_q    <= '0;
            discard_q <= discard_q + live_q - CW'(rsp_consumed);
        end else begin
            live_q    <= live_q + CW'(req_fire) - CW'(rsp_take);
            discard_q <= discard_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else if (jump_i) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            if (req_fire) begin
                tag_wr_q <= (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TW'(1);
            end
            if (rsp_take) begin
                tag_rd_q <= (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[fifo_wr_q]   <= tag_mem[tag_rd_q];
            fifo_inst[fifo_wr_q] <= mem_rsp_data_i;
        end
    end

    // Push and pop may coincide even when full; the credit check keeps push from ever overrunning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_count_q <= '0;
        end else if (jump_i) begin
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr_q <= fifo_wr_q + FW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_q <= fifo_rd_q + FW'(1);
            end
            fifo_count_q <= fifo_count_q + FCW'(fifo_push) - FCW'(fifo_pop);
        end
    end

    assign id_valid_o = (fifo_count_q != '0);
    assign id_pc_o    = id_valid_o ? fifo_pc[fifo_rd_q]   : '0;
    assign id_inst_o  = id_valid_o ? fifo_inst[fifo_rd_q] : '0;

`ifdef MXRV_IFU_MISALIGN_CHK_EN
    logic fault_q;

    // Sticky until an aligned redirect; the misaligned PC itself suppresses issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (jump_i && (jump_addr_i[1:0] == 2'b00)) begin
            fault_q <= 1'b0;
        end else if (pc_misaligned) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_mxrv_ifu.sv
// tb_mxrv_ifu: directed and randomised checks of mxrv_ifu against a bus model and a PC/instruction scoreboard.
// Also covers the MXRV_IFU_MISALIGN_CHK_EN build when that macro is defined.
module tb_mxrv_ifu;

    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk             = 1'b0;
    logic        rst             = 1'b1;
    logic        hold_i          = 1'b0;
    logic        jump_i          = 1'b0;
    logic [31:0] jump_addr_i     = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i  = '0;
    logic        id_valid_o;
    logic        id_ready_i      = 1'b1;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        fault_o;

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    rsp_t pend[$];
    exp_t sb[$];
    rsp_t r_tmp;
    exp_t e_tmp;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic        rdy_rand = 1'b0;
    logic [31:0] exp_pc   = RESET_PC;
    int          hs_count  = 0;
    int          pop_count = 0;
    int          first_req_cyc = -1;
    int          first_id_cyc  = -1;
    logic        first_hs_valid  = 1'b0;
    logic [31:0] first_hs_addr   = '0;
    logic        first_pop_valid = 1'b0;
    logic [31:0] first_pop_pc    = '0;

    mxrv_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .hold_i          (hold_i),
        .jump_i          (jump_i),
        .jump_addr_i     (jump_addr_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .id_valid_o      (id_valid_o),
        .id_ready_i      (id_ready_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .fault_o         (fault_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic j, input logic [31:0] ja, input logic idr);
        @(posedge clk);
        #1;
        hold_i      = h;
        jump_i      = j;
        jump_addr_i = ja;
        id_ready_i  = idr;
    endtask

    // Bus model: accepts per rdy_rand, answers in order after lat cycles, one response per cycle.
    always @(posedge clk) begin
        #1;
        mem_req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
        end
    end

    // Monitor: tracks expected PC, pushes expectations on accepted requests, compares on decode pops.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_pc = RESET_PC;
        end else begin
            if (jump_i || hold_i) begin
                checkOutput("req_blocked", 32'(mem_req_valid_o), 32'd0);
            end
            if (mem_req_valid_o) begin
                checkOutput("req_addr", mem_req_addr_o, exp_pc);
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                r_tmp.due  = cyc + lat;
                r_tmp.data = inst_of(mem_req_addr_o);
                pend.push_back(r_tmp);
                e_tmp.pc   = mem_req_addr_o;
                e_tmp.inst = inst_of(mem_req_addr_o);
                sb.push_back(e_tmp);
                exp_pc = exp_pc + 32'd4;
                hs_count++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (!first_hs_valid) begin
                    first_hs_valid = 1'b1;
                    first_hs_addr  = mem_req_addr_o;
                end
                checkOutput("outstanding_le_max", 32'(pend.size() <= MAX_OUT), 32'd1);
            end
            if (id_valid_o && first_id_cyc < 0) first_id_cyc = cyc;
            if (jump_i) begin
                sb.delete();
                exp_pc = jump_addr_i;
            end else if (id_valid_o && id_ready_i) begin
                checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e_tmp = sb.pop_front();
                    checkOutput("id_pc", id_pc_o, e_tmp.pc);
                    checkOutput("id_inst", id_inst_o, e_tmp.inst);
                end
                if (!first_pop_valid) begin
                    first_pop_valid = 1'b1;
                    first_pop_pc    = id_pc_o;
                end
                pop_count++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] ja;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        checkOutput("rst_req_addr", mem_req_addr_o, RESET_PC);
        checkOutput("rst_id_valid", 32'(id_valid_o), 32'd0);
        checkOutput("rst_id_pc", id_pc_o, 32'd0);
        checkOutput("rst_id_inst", id_inst_o, 32'd0);
        checkOutput("rst_fault", 32'(fault_o), 32'd0);

        // Streaming: 1-cycle memory, decode always ready.
        @(posedge clk);
        #1;
        rst = 1'b0;
        pop_count = 0;
        repeat (20) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("first_latency", 32'(first_id_cyc - first_req_cyc), 32'd2);
        checkOutput("stream_rate", 32'(pop_count >= 17), 32'd1);

        // Decode stalled: FIFO credits cap accepted requests at the buffer depth.
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0);
        hs_count = 0;
        repeat (15) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("full_hs_count", 32'(hs_count), 32'd4);
        checkOutput("full_id_valid", 32'(id_valid_o), 32'd1);
        hs_count = 0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("one_pop_one_credit", 32'(hs_count), 32'd1);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

        // 3-cycle memory with random bus and decode back-pressure.
        lat = 3;
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            applyStimulus(1'b0, 1'b0, 32'd0, r[0] | r[1]);
        end

        // Two in flight (0x10, 0x14) then redirect to 0x100.
        rdy_rand = 1'b0;
        repeat (8) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 1'b1);
        hs_count = 0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 20 && hs_count < 2; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("two_issued", 32'(hs_count >= 2), 32'd1);
        jump_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        hs_count = 0;
        first_hs_valid = 1'b0;
        first_pop_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("flush_empty", 32'(id_valid_o), 32'd0);
        for (int i = 0; i < 30 && !first_pop_valid; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("jump_first_req", first_hs_addr, 32'h0000_0100);
        checkOutput("jump_first_pop_seen", 32'(first_pop_valid), 32'd1);
        checkOutput("jump_first_pop_pc", first_pop_pc, 32'h0000_0100);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

        // Hold with one request outstanding.
        repeat (8) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        hs_count = 0;
        pop_count = 0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("hold_no_issue", 32'(hs_count), 32'd1);
        checkOutput("hold_drains", 32'(pop_count), 32'd1);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

        // PC wrap and back-to-back redirects.
        lat = 1;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_3000, 1'b1);
        first_pop_valid = 1'b0;
        repeat (15) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("b2b_first_pop_pc", first_pop_pc, 32'h0000_3000);

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        hs_count = 0;
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
`ifdef MXRV_IFU_MISALIGN_CHK_EN
        checkOutput("misalign_no_issue", 32'(hs_count), 32'd0);
        checkOutput("misalign_fault", 32'(fault_o), 32'd1);
`else
        checkOutput("misalign_passthru", 32'(hs_count >= 1), 32'd1);
        checkOutput("misalign_no_fault", 32'(fault_o), 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        first_hs_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("fault_cleared", 32'(fault_o), 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("resume_0x200", first_hs_addr, 32'h0000_0200);

        // Randomised traffic with holds and aligned redirects.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            ja = {r[31:2], 2'b00};
            lat = 1 + int'(r[11:10]) % 3;
            applyStimulus(r[1:0] == 2'b00, r[7:4] == 4'h0, ja, r[8] | r[9]);
        end

        // Reset mid-operation; late responses must be ignored.
        rdy_rand = 1'b0;
        lat = 3;
        repeat (6) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        hold_i = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req_valid", 32'(mem_req_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        first_hs_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
            @(negedge clk);
            checkOutput("midrst_no_stale", 32'(id_valid_o), 32'd0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("midrst_restart_pc", first_hs_addr, RESET_PC);

        // Final drain.
        repeat (12) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_bus_idle", 32'(pend.size()), 32'd0);
        checkOutput("drain_id_valid", 32'(id_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
